// File: rtl/mcc_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states and
// instruction field offsets.
package mcc_pkg;

    localparam int OP_W = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_ADDI = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_JMP  = 4'd8,
        OP_HALT = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    // Fields sit below the opcode in the order rd, rs1, rs2; imm overlaps rs2.
    function automatic int rd_lsb(input int instr_w, input int reg_aw);
        return instr_w - OP_W - reg_aw;
    endfunction

    function automatic int rs1_lsb(input int instr_w, input int reg_aw);
        return instr_w - OP_W - 2 * reg_aw;
    endfunction

    function automatic int rs2_lsb(input int instr_w, input int reg_aw);
        return instr_w - OP_W - 3 * reg_aw;
    endfunction

    function automatic int imm_w(input int instr_w, input int reg_aw);
        return instr_w - OP_W - 2 * reg_aw;
    endfunction

endpackage

// File: rtl/mcc_regfile.sv
// Register file with two combinational read ports and one write port;
// register 0 is hardwired to zero.
module mcc_regfile #(
    parameter int DATA_W = 24,
    parameter int REG_AW = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [2**REG_AW];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2**REG_AW; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/mcc_core.sv
// Multi-cycle load/store core: one instruction at a time through
// FETCH, DECODE, EXECUTE, MEM and WRITEBACK, with handshaked memories.
module mcc_core
    import mcc_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 11,
    parameter int REG_AW   = 3,
    parameter int INSTR_W  = 24,
    parameter int RESET_PC = 1024
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic               retire,
    output logic               halted,
    output logic               illegal,
    output logic [DATA_W-1:0]  program_out
);

    localparam int RD_LSB  = rd_lsb(INSTR_W, REG_AW);
    localparam int RS1_LSB = rs1_lsb(INSTR_W, REG_AW);
    localparam int RS2_LSB = rs2_lsb(INSTR_W, REG_AW);
    localparam int IMM_W   = imm_w(INSTR_W, REG_AW);

    state_t                    state;
    logic [ADDR_W-1:0]         pc;
    logic [INSTR_W-1:0]        ir;
    logic [OP_W-1:0]           op;
    logic [REG_AW-1:0]         rd, rs1, rs2, rf_raddr2;
    logic signed [IMM_W-1:0]   imm_s;
    logic signed [DATA_W-1:0]  imm_x;
    logic signed [DATA_W-1:0]  opa, opb, result;
    logic [DATA_W-1:0]         rf_rdata1, rf_rdata2;

    assign op        = ir[INSTR_W-1 -: OP_W];
    assign rd        = ir[RD_LSB +: REG_AW];
    assign rs1       = ir[RS1_LSB +: REG_AW];
    assign rs2       = ir[RS2_LSB +: REG_AW];
    assign imm_s     = ir[IMM_W-1:0];
    assign imm_x     = DATA_W'(imm_s);
    assign imem_addr = pc;
    // Stores need rd as data, so the second read port is steered to it.
    assign rf_raddr2 = (op == OP_SW) ? rd : rs2;

    mcc_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .raddr1 (rs1),
        .raddr2 (rf_raddr2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (state == S_WRITEBACK),
        .waddr  (rd),
        .wdata  (result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= ADDR_W'(RESET_PC);
            ir          <= '0;
            opa         <= '0;
            opb         <= '0;
            result      <= '0;
            program_out <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            retire      <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                // Request is raised one cycle after reset; later entries arrive with it set.
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        pc       <= pc + 1'b1;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opa   <= rf_rdata1;
                    opb   <= rf_rdata2;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (op)
                        OP_ADD:  begin result <= opa + opb;   state <= S_WRITEBACK; end
                        OP_SUB:  begin result <= opa - opb;   state <= S_WRITEBACK; end
                        OP_AND:  begin result <= opa & opb;   state <= S_WRITEBACK; end
                        OP_OR:   begin result <= opa | opb;   state <= S_WRITEBACK; end
                        OP_ADDI: begin result <= opa + imm_x; state <= S_WRITEBACK; end
                        OP_LW, OP_SW: begin
                            dmem_addr  <= ADDR_W'(opa + imm_x);
                            dmem_wdata <= opb;
                            dmem_we    <= (op == OP_SW);
                            dmem_req   <= 1'b1;
                            state      <= S_MEM;
                        end
                        OP_BEQ: begin
                            if (opa == opb) begin
                                pc <= pc + ADDR_W'(imm_x);
                            end
                            retire   <= 1'b1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_JMP: begin
                            pc       <= ADDR_W'($unsigned(imm_s));
                            retire   <= 1'b1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                            state   <= S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_req && dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (op == OP_LW) begin
                            result <= dmem_rdata;
                            state  <= S_WRITEBACK;
                        end else begin
                            retire   <= 1'b1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_WRITEBACK: begin
                    program_out <= result;
                    retire      <= 1'b1;
                    imem_req    <= 1'b1;
                    state       <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcc_core.sv
// Randomised and directed programs run against an ISA-level reference model;
// a monitor scoreboards every retire and every data-memory transfer.
module tb_mcc_core;

    localparam int DATA_W  = 24;
    localparam int ADDR_W  = 11;
    localparam int REG_AW  = 3;
    localparam int INSTR_W = 24;
    localparam logic [23:0] HALT_W = 24'hF00000;

    logic               clock, reset;
    logic               imem_req, imem_ack;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dmem_req, dmem_we, dmem_ack;
    logic [ADDR_W-1:0]  dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata, dmem_rdata;
    logic               retire, halted, illegal;
    logic [DATA_W-1:0]  program_out;

    mcc_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW),
               .INSTR_W(INSTR_W), .RESET_PC(1024)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .retire(retire), .halted(halted), .illegal(illegal), .program_out(program_out)
    );

    typedef struct packed { logic [23:0] pout; logic [10:0] npc; logic [31:0] lat; } exp_t;
    typedef struct packed { logic we; logic [10:0] addr; logic [23:0] wdata; } mem_t;

    exp_t        expq[$];
    mem_t        memq[$];
    int          iwq[$];
    int          dwq[$];
    logic [23:0] prog [2048];
    logic [23:0] dm   [2048];
    logic [23:0] md   [2048];
    int          n_checks = 0, n_pass = 0, cyc = 0, n_retire = 0;
    int          first_req = 0, last_ret = 0, last_lat = 0, last_dlen = 0;
    logic [10:0] first_addr = '0;
    bit          exp_illegal = 0, dm_manual = 0, dm_force_ack = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [23:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 11'd0};
    endfunction

    function automatic logic [23:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input int imm);
        logic [13:0] f;
        f = imm[13:0];
        return {op, rd, rs1, f};
    endfunction

    function automatic logic [23:0] enc_b(input logic [2:0] rs1, input logic [2:0] rs2, input int off);
        logic [10:0] f;
        f = off[10:0];
        return {4'd7, 3'd0, rs1, rs2, f};
    endfunction

    // Instruction memory: fixed or random wait states drawn by the model.
    initial begin : imem_resp
        bit busy;
        int left;
        busy = 0; left = 0; imem_ack = 0; imem_rdata = '0;
        forever begin
            @(negedge clock);
            imem_ack = 0;
            if (reset) busy = 0;
            else if (imem_req) begin
                if (!busy) begin
                    busy = 1;
                    left = (iwq.size() > 0) ? iwq.pop_front() : 0;
                end
                if (left == 0) begin
                    imem_ack = 1; imem_rdata = prog[imem_addr]; busy = 0;
                end else left--;
            end
        end
    end

    initial begin : dmem_resp
        bit busy;
        int left;
        mem_t m;
        busy = 0; left = 0; dmem_ack = 0; dmem_rdata = '0;
        forever begin
            @(negedge clock);
            dmem_ack = 0;
            if (dm_manual) begin
                dmem_ack = dm_force_ack; busy = 0;
            end else if (reset) busy = 0;
            else if (dmem_req) begin
                if (!busy) begin
                    busy = 1;
                    left = (dwq.size() > 0) ? dwq.pop_front() : 0;
                end
                if (left == 0) begin
                    dmem_ack = 1; busy = 0;
                    if (memq.size() == 0) begin
                        n_checks++;
                        $display("FAIL mem_unexpected: got access at 0x%0h, expected none", dmem_addr);
                    end else begin
                        m = memq.pop_front();
                        check("mem_we", 32'(dmem_we), 32'(m.we));
                        check("mem_addr", 32'(dmem_addr), 32'(m.addr));
                        if (m.we) check("mem_wdata", 32'(dmem_wdata), 32'(m.wdata));
                    end
                    if (dmem_we) dm[dmem_addr] = dmem_wdata;
                    else dmem_rdata = dm[dmem_addr];
                end else left--;
            end
        end
    end

    initial begin : monitor
        bit   started;
        int   start, dlen;
        exp_t e;
        started = 0; start = 0; dlen = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                started = 0; dlen = 0;
            end else begin
                if (retire) begin
                    n_retire++;
                    last_ret = cyc;
                    last_lat = cyc - start;
                    if (expq.size() == 0) begin
                        n_checks++;
                        $display("FAIL retire_unexpected: got retire with pc 0x%0h, expected none", imem_addr);
                    end else begin
                        e = expq.pop_front();
                        check("retire_pout", 32'(program_out), 32'(e.pout));
                        check("retire_next_pc", 32'(imem_addr), 32'(e.npc));
                        check("retire_latency", 32'(last_lat), e.lat);
                    end
                    start = cyc;
                end
                if (!started && imem_req) begin
                    started = 1; start = cyc; first_req = cyc; first_addr = imem_addr;
                end
                if (dmem_req) dlen++;
                else if (dlen != 0) begin
                    last_dlen = dlen; dlen = 0;
                end
            end
        end
    end

    // Architectural interpreter: queues per-retire expectations and wait states.
    task automatic model_run(input int imin, input int imax, input int dmin, input int dmax);
        logic [23:0] r [8];
        logic [23:0] ins, a, b, imm, val, sum, pout;
        logic [10:0] pc, addr;
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2;
        int          lat, w;
        bit          done, wr;
        exp_t        e;
        mem_t        m;
        for (int i = 0; i < 8; i++) r[i] = '0;
        pc = 11'd1024; pout = '0; exp_illegal = 0;
        for (int step = 0; step < 500; step++) begin
            ins = prog[pc];
            w = $urandom_range(imax, imin); iwq.push_back(w); lat = w;
            op = ins[23:20]; rd = ins[19:17]; rs1 = ins[16:14]; rs2 = ins[13:11];
            imm = {{10{ins[13]}}, ins[13:0]};
            a = r[rs1]; b = r[rs2];
            pc = pc + 11'd1;
            done = 0; wr = 0; val = '0;
            sum = a + imm; addr = sum[10:0];
            case (op)
                4'd0: begin val = a + b; wr = 1; lat += 4; end
                4'd1: begin val = a - b; wr = 1; lat += 4; end
                4'd2: begin val = a & b; wr = 1; lat += 4; end
                4'd3: begin val = a | b; wr = 1; lat += 4; end
                4'd4: begin val = sum;   wr = 1; lat += 4; end
                4'd5: begin
                    w = $urandom_range(dmax, dmin); dwq.push_back(w);
                    m.we = 0; m.addr = addr; m.wdata = '0; memq.push_back(m);
                    val = md[addr]; wr = 1; lat += 5 + w;
                end
                4'd6: begin
                    w = $urandom_range(dmax, dmin); dwq.push_back(w);
                    m.we = 1; m.addr = addr; m.wdata = r[rd]; memq.push_back(m);
                    md[addr] = r[rd]; lat += 4 + w;
                end
                4'd7: begin if (a == b) pc = pc + imm[10:0]; lat += 3; end
                4'd8: begin pc = ins[10:0]; lat += 3; end
                4'd15: done = 1;
                default: begin done = 1; exp_illegal = 1; end
            endcase
            if (done) break;
            if (wr) begin
                if (rd != 0) r[rd] = val;
                pout = val;
            end
            e.pout = pout; e.npc = pc; e.lat = 32'(lat);
            expq.push_back(e);
        end
    endtask

    task automatic begin_test();
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        iwq.delete(); dwq.delete(); expq.delete(); memq.delete();
        for (int i = 0; i < 2048; i++) prog[i] = HALT_W;
    endtask

    task automatic go(input string tag);
        bit quiet;
        reset = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clock); #1;
            if (halted) break;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
        check({tag, "_illegal"}, 32'(illegal), 32'(exp_illegal));
        check({tag, "_pending_retires"}, 32'(expq.size()), 32'd0);
        check({tag, "_pending_mem"}, 32'(memq.size()), 32'd0);
        quiet = 1;
        repeat (4) begin
            @(posedge clock); #1;
            if (imem_req || dmem_req || retire) quiet = 0;
        end
        check({tag, "_quiet_after_halt"}, 32'(quiet), 32'd1);
    endtask

    initial begin
        int nr0, L, k, a, off;
        bit seen;
        reset = 1;
        for (int i = 0; i < 2048; i++) begin
            dm[i] = 24'($urandom); md[i] = dm[i]; prog[i] = HALT_W;
        end

        // ADDI/ADDI/ADD with zero-wait instruction memory
        begin_test();
        prog[1024] = enc_i(4'd4, 3'd1, 3'd0, 5);
        prog[1025] = enc_i(4'd4, 3'd2, 3'd0, -3);
        prog[1026] = enc_r(4'd0, 3'd3, 3'd1, 3'd2);
        model_run(0, 0, 0, 0);
        go("alu");
        check("alu_first_fetch", 32'(first_addr), 32'd1024);
        check("alu_total_cycles", 32'(last_ret - first_req), 32'd12);
        check("alu_program_out", 32'(program_out), 32'd2);

        // Store then load with three data wait states
        begin_test();
        prog[1024] = enc_i(4'd4, 3'd1, 3'd0, 5);
        prog[1025] = enc_i(4'd6, 3'd1, 3'd0, 20);
        prog[1026] = enc_i(4'd5, 3'd4, 3'd0, 20);
        model_run(0, 0, 3, 3);
        go("ldst");
        check("ldst_mem20", 32'(dm[20]), 32'd5);
        check("ldst_r4", 32'(program_out), 32'd5);
        check("ldst_lw_cycles", 32'(last_lat), 32'd8);
        check("ldst_req_hold", 32'(last_dlen), 32'd4);

        // Branches and jumps
        begin_test();
        prog[1024] = enc_b(3'd7, 3'd0, 1);
        prog[1026] = enc_i(4'd4, 3'd7, 3'd0, 1);
        prog[1027] = enc_i(4'd8, 3'd0, 3'd0, 1030);
        prog[1030] = enc_b(3'd0, 3'd0, 2);
        prog[1033] = enc_i(4'd8, 3'd0, 3'd0, 1024);
        model_run(0, 1, 0, 0);
        go("branch");
        check("branch_program_out", 32'(program_out), 32'd1);

        // Data and PC wrap
        begin_test();
        prog[1024] = enc_i(4'd4, 3'd1, 3'd0, -1);
        prog[1025] = enc_r(4'd0, 3'd1, 3'd1, 3'd1);
        prog[1026] = enc_i(4'd8, 3'd0, 3'd0, 2047);
        prog[2047] = enc_i(4'd4, 3'd2, 3'd0, 9);
        model_run(0, 0, 0, 0);
        go("wrap");
        check("wrap_program_out", 32'(program_out), 32'd9);
        check("wrap_pc", 32'(imem_addr), 32'd1);

        // Illegal opcode, then reset values
        begin_test();
        prog[1024] = enc_i(4'd4, 3'd1, 3'd0, 5);
        prog[1025] = {4'd12, 20'd0};
        model_run(0, 0, 0, 0);
        go("illegal");
        reset = 1;
        @(posedge clock); #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_program_out", 32'(program_out), 32'd0);
        check("rst_pc", 32'(imem_addr), 32'd1024);

        // Random programs placed across the PC wrap
        for (int t = 0; t < 3; t++) begin
            begin_test();
            L = 24;
            prog[1024] = enc_i(4'd8, 3'd0, 3'd0, 2040);
            for (k = 0; k < L; k++) begin
                a = (2040 + k) % 2048;
                case ($urandom_range(7, 0))
                    0: prog[a] = enc_r(4'd0, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
                    1: prog[a] = enc_r(4'd1, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
                    2: prog[a] = enc_r(4'd2, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
                    3: prog[a] = enc_r(4'd3, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
                    4: prog[a] = enc_i(4'd4, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), int'($urandom_range(16383, 0)));
                    5: prog[a] = enc_i(4'd5, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), int'($urandom_range(16383, 0)));
                    6: prog[a] = enc_i(4'd6, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), int'($urandom_range(16383, 0)));
                    default: begin
                        off = int'($urandom_range((L - 1 - k) < 2 ? (L - 1 - k) : 2, 0));
                        prog[a] = enc_b(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), off);
                    end
                endcase
            end
            model_run(0, 2, 0, 3);
            go("random");
        end

        // Reset while a load is outstanding, then a late data ack
        begin_test();
        prog[1024] = enc_i(4'd5, 3'd4, 3'd0, 20);
        dm_manual = 1; dm_force_ack = 0;
        reset = 0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (dmem_req) begin seen = 1; break; end
        end
        check("midrst_dmem_req_seen", 32'(seen), 32'd1);
        repeat (3) begin @(posedge clock); #1; end
        reset = 1;
        @(posedge clock); #1;
        check("midrst_dmem_req", 32'(dmem_req), 32'd0);
        check("midrst_imem_req", 32'(imem_req), 32'd0);
        check("midrst_retire", 32'(retire), 32'd0);
        nr0 = n_retire;
        reset = 0;
        dm_force_ack = 1;
        repeat (2) begin @(posedge clock); #1; end
        dm_force_ack = 0;
        repeat (6) begin @(posedge clock); #1; end
        check("midrst_next_fetch", 32'(first_addr), 32'd1024);
        check("midrst_no_retire", 32'(n_retire - nr0), 32'd0);
        check("midrst_program_out", 32'(program_out), 32'd0);
        reset = 1;
        @(posedge clock); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mcc_core.md
MCC_CORE -- requirements
Module: mcc_core

Interface
REQ-001 Parameter DATA_W, default 24, datapath and register width.
REQ-002 Parameter ADDR_W, default 11, instruction/data address width.
REQ-003 Parameter REG_AW, default 3, register-file address bits (2**REG_AW registers).
REQ-004 Parameter INSTR_W, default 24, instruction width.
REQ-005 Parameter RESET_PC, default 1024, PC value after reset.
REQ-006 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 imem_req  out  1  instruction fetch request; imem_addr  out  ADDR_W  fetch address.
REQ-009 imem_ack  in  1  fetch complete; imem_rdata  in  INSTR_W  instruction, valid when imem_ack=1.
REQ-010 dmem_req  out  1  data request; dmem_we  out  1  1=store, 0=load.
REQ-011 dmem_addr  out  ADDR_W; dmem_wdata  out  DATA_W; dmem_rdata  in  DATA_W; dmem_ack  in  1  transfer complete.
REQ-012 retire  out  1  one-cycle pulse per completed instruction; halted  out  1  core stopped; illegal  out  1  stop caused by an undefined opcode.
REQ-013 program_out  out  DATA_W  last value written to the register file.

Function
REQ-014 Instruction fields: op = top 4 bits; then rd, rs1, rs2 (REG_AW each); imm = low INSTR_W-4-2*REG_AW bits, sign-extended to DATA_W.
REQ-015 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI (rd=rs1+imm), 5 LW (rd=mem[rs1+imm]), 6 SW (mem[rs1+imm]=rd), 7 BEQ (rs1==rs2 -> PC=PC+1+imm), 8 JMP (PC=imm zero-extended), 15 HALT; all others illegal.
REQ-016 FSM states: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-017 FETCH: imem_req=1 with imem_addr=PC until imem_ack=1; on ack capture IR, PC=PC+1, go to DECODE.
REQ-018 DECODE: latch rs1/rs2/rd operands; go to EXECUTE.
REQ-019 EXECUTE: ALU ops and ADDI -> WRITEBACK; LW/SW -> MEM; BEQ/JMP update PC, pulse retire, go to FETCH; HALT or illegal opcode -> HALT.
REQ-020 MEM: dmem_req=1 with address, we and wdata stable until dmem_ack=1; LW -> WRITEBACK capturing dmem_rdata; SW pulses retire, goes to FETCH.
REQ-021 WRITEBACK: write rd, update program_out, pulse retire, go to FETCH.
REQ-022 Zero-wait latency (ack in the request cycle): ALU/ADDI/LW-address path = 4 cycles; LW = 5; SW = 4; BEQ/JMP = 3.
REQ-023 ack is accepted in the same cycle as req; ack while req=0 SHALL be ignored; no new request is issued in the cycle following an ack.
REQ-024 Register 0 reads as zero; writes to register 0 are discarded, but retire and program_out still update.
REQ-025 Arithmetic is modulo 2**DATA_W; PC and addresses wrap modulo 2**ADDR_W; addresses use the low ADDR_W bits of the ALU result.
REQ-026 HALT is terminal until reset: halted=1, no requests issued, retire=0.

Reset
REQ-027 On reset: PC=RESET_PC, state=FETCH, all registers=0, IR=0, program_out=0, imem_req=dmem_req=dmem_we=0, retire=halted=illegal=0.
REQ-028 Reset mid-transaction abandons the outstanding request; req is 0 in the cycle following the reset edge, and a late ack is ignored.

Structure
REQ-029 Opcode codes, state encodings and field-offset functions SHALL be defined in shared package mcc_pkg.
REQ-030 The register file SHALL be a sub-module mcc_regfile with two read ports and one write port, parametrised by DATA_W and REG_AW.

Verification
REQ-031 Reset, zero-wait imem, program ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 -> first imem_addr=1024; program_out=2 after the third retire; 12 cycles total.
REQ-032 Load/store with 3 wait states on dmem: SW r1 (value 5) to address 20; LW r4 from 20 -> dmem_req held 4 cycles per access; r4=5; LW takes 8 cycles.
REQ-033 Branches: BEQ r0,r0,+2 at PC 1030 -> next fetch address 1033; JMP 1024 -> next fetch address 1024.
REQ-034 Wrap: ADDI r1,r0,-1 then ADD r1,r1,r1 -> r1=0xFFFFFE (DATA_W=24); PC 2047 increments to 0.
REQ-035 Opcode 12 -> illegal=1 and halted=1 after EXECUTE, no further imem_req; assert reset -> all outputs return to reset values.
REQ-036 Assert reset while dmem_req=1 and ack withheld, then drive ack after reset -> no register write, no retire, next fetch at 1024.
